// File: rtl/mc_defs_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings, ALU codes,
// opcode/funct values and datapath mux select values.
package mc_defs;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StRWb     = 4'd7,
        StExecI   = 4'd8,
        StIWb     = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StHalt    = 4'd12
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_OR   = 6'b100101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decode: R-type code from funct, I-type code from op.
module mc_alu_dec
    import mc_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] r_aluc,
    output logic [2:0] i_aluc
);

    always_comb begin
        r_aluc = ALU_ADD;
        case (funct)
            FN_SUBU: r_aluc = ALU_SUB;
            FN_OR:   r_aluc = ALU_OR;
            FN_SLL:  r_aluc = ALU_SLL;
            default: r_aluc = ALU_ADD;
        endcase
    end

    assign i_aluc = (op == OP_ORI) ? ALU_OR : ALU_ADD;

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and counts retired instructions.
module mc_control
    import mc_defs::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [2:0]       aluc,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_op,
    output logic [1:0]       pc_source,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic [2:0]       r_aluc, i_aluc;
    logic             r_funct_ok;

    mc_alu_dec u_alu_dec (
        .op     (op),
        .funct  (funct),
        .r_aluc (r_aluc),
        .i_aluc (i_aluc)
    );

    assign r_funct_ok = (funct == FN_ADDU) || (funct == FN_SUBU) ||
                        (funct == FN_OR)   || (funct == FN_SLL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        aluc       = ALU_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        ext_op     = 1'b0;
        pc_source  = PCSRC_ALU;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_en     = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                // Branch target is computed speculatively and parked in ALUOut.
                alu_src_b = SRCB_IMM_SH2;
                ext_op    = 1'b1;
                case (op)
                    OP_LW, OP_SW:     state_d = StMemAddr;
                    OP_RTYPE:         state_d = r_funct_ok ? StExecR : StHalt;
                    OP_ADDIU, OP_ORI: state_d = StExecI;
                    OP_BEQ, OP_BNE:   state_d = StBranch;
                    OP_J:             state_d = StJump;
                    default:          state_d = StHalt;
                endcase
            end
            StMemAddr: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                ext_op    = 1'b1;
                state_d   = (op == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StExecR: begin
                aluc      = r_aluc;
                alu_src_a = (funct == FN_SLL) ? SRCA_SHAMT : SRCA_REG;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StExecI: begin
                aluc      = i_aluc;
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                ext_op    = (op != OP_ORI);
                state_d   = StIWb;
            end
            StIWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                aluc      = ALU_SUB;
                alu_src_a = SRCA_REG;
                pc_source = PCSRC_ALUOUT;
                pc_en     = (op == OP_BNE) ? ~zero : zero;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_source = PCSRC_JUMP;
                pc_en     = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StHalt: begin
                halted  = 1'b1;
                state_d = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase

        // Reset holds state at FETCH, whose outputs are active; mask everything here.
        if (rst) begin
            aluc       = ALU_ADD;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_REG;
            ext_op     = 1'b0;
            pc_source  = PCSRC_ALU;
            pc_en      = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            halted     = 1'b0;
        end
    end

    assign retired   = retired_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control against an instruction-level cycle model.
module tb_mc_control;
    import mc_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic [2:0]  aluc;
    logic [1:0]  alu_src_a, alu_src_b, pc_source;
    logic        ext_op, pc_en, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, halted;
    logic [31:0] retired;
    logic [3:0]  state_dbg;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_retired = 32'd0;
    logic [18:0] act;

    always #5 clk = ~clk;

    mc_control #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .aluc       (aluc),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .pc_source  (pc_source),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .halted     (halted),
        .retired    (retired),
        .state_dbg  (state_dbg)
    );

    assign act = {aluc, alu_src_a, alu_src_b, ext_op, pc_source, pc_en, iord,
                  mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, halted};

    function automatic bit is_legal(logic [5:0] o, logic [5:0] f);
        if (o == 6'b000000)
            return (f == 6'b100001) || (f == 6'b100011) || (f == 6'b100101) || (f == 6'b000000);
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b001001) || (o == 6'b001101) ||
               (o == 6'b000100) || (o == 6'b000101) || (o == 6'b000010);
    endfunction

    function automatic int lat_of(logic [5:0] o, logic [5:0] f);
        if (!is_legal(o, f)) return 3;
        if (o == 6'b100011) return 5;
        if (o == 6'b000100 || o == 6'b000101 || o == 6'b000010) return 3;
        return 4;
    endfunction

    // Expected output vector for cycle c (0 = fetch) of an instruction.
    function automatic logic [18:0] exp_out(logic [5:0] o, logic [5:0] f, logic z, int c);
        logic [2:0] al;
        logic [1:0] sa, sb, ps;
        logic ex, pe, io, mr, mw, iw, rd, m2r, rw, h;
        al = 3'b000; sa = 2'b00; sb = 2'b00; ps = 2'b00;
        ex = 0; pe = 0; io = 0; mr = 0; mw = 0; iw = 0; rd = 0; m2r = 0; rw = 0; h = 0;
        if (c == 0) begin
            mr = 1; iw = 1; sb = 2'b01; pe = 1;
        end else if (c == 1) begin
            sb = 2'b11; ex = 1;
        end else if (!is_legal(o, f)) begin
            h = 1;
        end else if (o == 6'b100011 || o == 6'b101011) begin
            if (c == 2) begin
                sa = 2'b01; sb = 2'b10; ex = 1;
            end else if (c == 3) begin
                io = 1;
                if (o == 6'b100011) mr = 1;
                else mw = 1;
            end else begin
                rw = 1; m2r = 1;
            end
        end else if (o == 6'b000000) begin
            if (c == 2) begin
                case (f)
                    6'b100001: begin al = 3'b000; sa = 2'b01; end
                    6'b100011: begin al = 3'b001; sa = 2'b01; end
                    6'b100101: begin al = 3'b010; sa = 2'b01; end
                    default:   begin al = 3'b011; sa = 2'b10; end
                endcase
            end else begin
                rw = 1; rd = 1;
            end
        end else if (o == 6'b001001 || o == 6'b001101) begin
            if (c == 2) begin
                sa = 2'b01; sb = 2'b10;
                if (o == 6'b001101) al = 3'b010;
                else ex = 1;
            end else begin
                rw = 1;
            end
        end else if (o == 6'b000010) begin
            ps = 2'b10; pe = 1;
        end else begin
            sa = 2'b01; al = 3'b001; ps = 2'b01;
            pe = (o == 6'b000100) ? z : ~z;
        end
        return {al, sa, sb, ex, ps, pe, io, mr, mw, iw, rd, m2r, rw, h};
    endfunction

    // zmode: 0/1 force zero, 2 random per cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
        int n;
        logic [18:0] e;
        n = lat_of(o, f);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            op = o;
            funct = f;
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            #1;
            e = exp_out(o, f, zero, c);
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL outputs op=%b funct=%b cyc=%0d zero=%b got=%b want=%b",
                         o, f, c, zero, act, e);
            end
            n_cmp++;
            if (retired !== exp_retired) begin
                n_fail++;
                $display("FAIL retired op=%b cyc=%0d got=%0d want=%0d", o, c, retired, exp_retired);
            end
            if (c == 0) begin
                n_cmp++;
                if (state_dbg !== StFetch) begin
                    n_fail++;
                    $display("FAIL fetch_state op=%b got=%0d want=%0d", o, state_dbg, StFetch);
                end
            end
        end
        if (is_legal(o, f)) exp_retired++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_retired = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (act !== 19'd0 || state_dbg !== StFetch || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL reset got outs=%b state=%0d retired=%0d want 0/%0d/0",
                     act, state_dbg, retired, StFetch);
        end
        rst = 1'b0;
        exp_retired = 32'd0;
    endtask

    task automatic test_alu_ops();
        run_instr(6'b000000, 6'b100001, 2);
        run_instr(6'b000000, 6'b000000, 2);
        run_instr(6'b000000, 6'b100011, 2);
        run_instr(6'b000000, 6'b100101, 2);
        run_instr(6'b001101, 6'($urandom), 2);
        run_instr(6'b001001, 6'($urandom), 2);
    endtask

    task automatic test_lw_sw();
        run_instr(6'b100011, 6'($urandom), 2);
        run_instr(6'b101011, 6'($urandom), 2);
    endtask

    task automatic test_branch();
        run_instr(6'b000100, 6'($urandom), 1);
        run_instr(6'b000100, 6'($urandom), 0);
        run_instr(6'b000101, 6'($urandom), 0);
        run_instr(6'b000101, 6'($urandom), 1);
        run_instr(6'b000010, 6'($urandom), 2);
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        logic [5:0] fns [4];
        logic [5:0] o, f;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001001, 6'b001101,
                6'b000100, 6'b000101, 6'b000010};
        fns = '{6'b100001, 6'b100011, 6'b100101, 6'b000000};
        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 7)];
            f = (o == 6'b000000) ? fns[$urandom_range(0, 3)] : 6'($urandom);
            run_instr(o, f, 2);
        end
    endtask

    task automatic test_halt();
        run_instr(6'b111111, 6'($urandom), 2);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            zero = 1'($urandom_range(0, 1));
            op = 6'($urandom);
            #1;
            n_cmp++;
            if (act !== 19'd1 || state_dbg !== StHalt || retired !== exp_retired) begin
                n_fail++;
                $display("FAIL halt_hold cyc=%0d got outs=%b state=%0d want outs=%b state=%0d",
                         i, act, state_dbg, 19'd1, StHalt);
            end
        end
        do_reset();
        n_cmp++;
        if (halted !== 1'b0 || state_dbg !== StFetch) begin
            n_fail++;
            $display("FAIL halt_clear got halted=%b state=%0d want 0/%0d", halted, state_dbg, StFetch);
        end
        run_instr(6'b000000, 6'b000000, 2);
        run_instr(6'b000000, 6'b101010, 2);
        do_reset();
    endtask

    task automatic test_reset_mid_wb();
        logic [18:0] e;
        run_instr(6'b001001, 6'd0, 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            op = 6'b100011;
            #1;
            e = exp_out(6'b100011, 6'd0, zero, c);
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL mid_lw cyc=%0d got=%b want=%b", c, act, e);
            end
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (reg_write !== 1'b0 || act !== 19'd0 || state_dbg !== StFetch || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_wb_reset got outs=%b state=%0d retired=%0d want 0/%0d/0",
                     act, state_dbg, retired, StFetch);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_retired = 32'd0;
        run_instr(6'b101011, 6'd0, 2);
        run_instr(6'b000010, 6'd0, 2);
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_lw_sw();
        test_branch();
        test_random();
        test_halt();
        test_reset_mid_wb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Multi-cycle control FSM that drives the datapath ALU's 3-bit aluc code and consumes its zero flag. It decodes op/funct from the instruction register and sequences fetch, decode, execute, memory and writeback. It issues all datapath mux selects and write enables for a small MIPS subset, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag, combinational, same cycle.
- aluc  out  3  ALU operation: 000 add, 001 sub, 010 or, 011 shift-left (b << a[4:0]).
- alu_src_a  out  2  ALU A input select: 00 PC, 01 reg A, 10 zero-extended shamt.
- alu_src_b  out  2  ALU B input select: 00 reg B, 01 constant 4, 10 extended imm, 11 extended imm<<2.
- ext_op  out  1  immediate extension: 1 sign-extend, 0 zero-extend.
- pc_source  out  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
- pc_en  out  1  PC write enable, with branch condition already resolved.
- iord  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  register file destination: 1 rd, 0 rt.
- mem_to_reg  out  1  writeback data: 1 MDR, 0 ALUOut.
- reg_write  out  1  register file write enable.
- halted  out  1  set when an illegal opcode is decoded.
- retired  out  CNT_W  count of completed instructions.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (async, rst=1):
  - state goes to FETCH; retired=0; halted=0.
  - While rst is high, all enables/strobes are forced to 0 (pc_en, ir_write, mem_read, mem_write, reg_write). Selects read 0.
- Outputs are a combinational function of state. aluc additionally depends on funct in EXEC_R, and on op in EXEC_I. pc_en additionally depends on zero in BRANCH.
- States and output assertions (unlisted outputs = 0):
  - FETCH: mem_read=1, iord=0, ir_write=1, src_a=00, src_b=01, aluc=000, pc_source=00, pc_en=1. Next state: DECODE.
  - DECODE: src_a=00, src_b=11, ext_op=1, aluc=000 (branch target goes to ALUOut). Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
    - 000000 with funct in {100001 addu, 100011 subu, 100101 or, 000000 sll} -> EXEC_R.
    - 001001 (addiu) or 001101 (ori) -> EXEC_I.
    - 000100 (beq) or 000101 (bne) -> BRANCH.
    - 000010 (j) -> JUMP.
    - anything else -> HALT.
  - MEM_ADDR: src_a=01, src_b=10, ext_op=1, aluc=000. Next state: MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: mem_read=1, iord=1. Next state: MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; retire. Next state: FETCH.
  - MEM_WR: mem_write=1, iord=1; retire. Next state: FETCH.
  - EXEC_R: aluc = 000 / 001 / 010 / 011 for addu / subu / or / sll. src_b=00. src_a=10 for sll, else 01. Next state: R_WB.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; retire. Next state: FETCH.
  - EXEC_I: src_a=01, src_b=10. addiu: ext_op=1, aluc=000. ori: ext_op=0, aluc=010. Next state: I_WB.
  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; retire. Next state: FETCH.
  - BRANCH: src_a=01, src_b=00, aluc=001, pc_source=01. pc_en = zero for beq, ~zero for bne. Retire (taken or not). Next state: FETCH.
  - JUMP: pc_source=10, pc_en=1; retire. Next state: FETCH.
  - HALT: halted=1, all enables 0. Terminal until reset.
- Latency in cycles: lw 5; sw, R-type, I-type 4; beq, bne, j 3.
- "Retire" means retired increments by 1 on the clock edge leaving that state. The counter wraps modulo 2^CNT_W with no saturation.
- op/funct are sampled only in DECODE and in the EXEC states; they are stable there because the IR is loaded only in FETCH.
- Reset asserted mid-instruction aborts immediately. No partial write-enable pulse occurs in the reset cycle. Operation restarts at FETCH on the first edge after rst deasserts.
- Unused state encodings fall to HALT.

Decomposition:
- Shared package (mc_defs): state encodings; the 4 aluc codes (ALU_ADD, ALU_SUB, ALU_OR, ALU_SLL); opcode and funct constants; mux select constants.
- The ALU uses the same aluc constants from this package.
- One natural sub-module: mc_alu_dec (combinational funct/op -> aluc). All other logic stays in mc_control.

Test Plan:
- addu: op=000000, funct=100001 after reset -> states FETCH, DECODE, EXEC_R, R_WB. aluc=000 in EXEC_R. reg_write=1 and reg_dst=1 in cycle 4. retired 0->1.
- sll: op=000000, funct=000000 -> in EXEC_R, aluc=011 and alu_src_a=10. ori: op=001101 -> in EXEC_I, aluc=010 and ext_op=0.
- lw followed by sw -> 5 + 4 cycles. mem_read with iord=1 in cycle 4 of lw; mem_write=1 in cycle 4 of sw. retired=2.
- beq: zero=1 -> pc_en=1, pc_source=01 in BRANCH. zero=0 -> pc_en=0. bne with zero=0 -> pc_en=1. All take 3 cycles.
- Illegal op=111111 -> HALT after DECODE. halted=1 and all enables 0 for 20+ cycles. rst clears halted and returns to FETCH.
- Async reset asserted mid-MEM_WB -> reg_write drops the same cycle (no clock edge). state_dbg=FETCH and retired=0 after reset.
